// File: rtl/ms_pkg.sv
// Shared types and defaults for the minesweeper sequencer slice.
package ms_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_PLACE      = 4'd1,
    ST_WAIT_GUESS = 4'd2,
    ST_LOAD       = 4'd3,
    ST_DECODE     = 4'd4,
    ST_ALU        = 4'd5,
    ST_DISPLAY    = 4'd6,
    ST_OVER       = 4'd7,
    ST_FAULT      = 4'd8
  } state_t;

  localparam int CELLS_DEF  = 25;
  localparam int ADDR_W_DEF = 5;
  localparam int TURN_W     = 5;

  // States that sit waiting on a done level from dp and are guarded by the watchdog.
  function automatic logic is_wait_state(state_t s);
    return (s == ST_PLACE) || (s == ST_DECODE) || (s == ST_ALU) || (s == ST_DISPLAY);
  endfunction

endpackage

// File: rtl/ms_watchdog.sv
// Per-state cycle counter; flags expiry when a wait state has lasted TIMEOUT cycles.
module ms_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clka,
  input  logic restart,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);
  localparam logic [7:0] LAST  = 8'(TIMEOUT - 1);

  logic [7:0] cnt;
  logic [7:0] cnt_eff;

  // clr marks the first cycle of a new state, so the stale count is ignored there.
  assign cnt_eff = clr ? 8'd0 : cnt;
  assign expired = en && (cnt_eff >= LAST);

  always_ff @(posedge clka) begin
    if (restart) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt_eff != LIMIT) begin
      cnt <= cnt_eff + 8'd1;
    end else begin
      cnt <= cnt_eff;
    end
  end

endmodule

// File: rtl/ms_seq_ctrl.sv
// Minesweeper sequencer: accepts guesses and walks each through load/decode/alu/display.
module ms_seq_ctrl
  import ms_pkg::*;
#(
  parameter int CELLS   = CELLS_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clka,
  input  logic              restart,
  input  logic              new_game,
  input  logic              guess_valid,
  input  logic [ADDR_W-1:0] guess,
  output logic              guess_ready,
  input  logic              place_done,
  input  logic              decode_done,
  input  logic              alu_done,
  input  logic              display_done,
  input  logic              gameover,
  input  logic              win,
  output logic              start,
  output logic              load,
  output logic              decode,
  output logic              alu,
  output logic              display,
  output logic [ADDR_W-1:0] data,
  output logic [3:0]        state,
  output logic [TURN_W-1:0] turns,
  output logic              won,
  output logic              lost,
  output logic              fault,
  output logic              bad_guess
);

  localparam logic [ADDR_W:0]   CELLS_L  = (ADDR_W + 1)'(CELLS);
  localparam logic [TURN_W-1:0] TURN_MAX = '1;

  state_t st, nxt;
  logic   accept, reject, set_won, set_lost, set_fault, clr_status;
  logic   in_range;
  logic   wd_clr, wd_en, wd_expired;

  assign in_range = {1'b0, guess} < CELLS_L;
  assign wd_en    = is_wait_state(st);
  assign state    = st;

  ms_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clka    (clka),
    .restart (restart),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Only the done matching the current phase is looked at; a done beats a same-cycle expiry.
  always_comb begin
    nxt        = st;
    accept     = 1'b0;
    reject     = 1'b0;
    set_won    = 1'b0;
    set_lost   = 1'b0;
    set_fault  = 1'b0;
    clr_status = 1'b0;
    case (st)
      ST_IDLE, ST_OVER, ST_FAULT: begin
        if (new_game) begin
          nxt        = ST_PLACE;
          clr_status = 1'b1;
        end
      end
      ST_WAIT_GUESS: begin
        if (new_game) begin
          nxt        = ST_PLACE;
          clr_status = 1'b1;
        end else if (guess_valid) begin
          if (in_range) begin
            accept = 1'b1;
            nxt    = ST_LOAD;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_PLACE: begin
        if (place_done) begin
          nxt = ST_WAIT_GUESS;
        end else if (wd_expired) begin
          nxt       = ST_FAULT;
          set_fault = 1'b1;
        end
      end
      ST_LOAD: nxt = ST_DECODE;
      ST_DECODE: begin
        if (decode_done) begin
          nxt = ST_ALU;
        end else if (wd_expired) begin
          nxt       = ST_FAULT;
          set_fault = 1'b1;
        end
      end
      ST_ALU: begin
        if (alu_done) begin
          nxt = ST_DISPLAY;
        end else if (wd_expired) begin
          nxt       = ST_FAULT;
          set_fault = 1'b1;
        end
      end
      ST_DISPLAY: begin
        if (display_done) begin
          if (gameover) begin
            nxt      = ST_OVER;
            set_won  = win;
            set_lost = !win;
          end else begin
            nxt = ST_WAIT_GUESS;
          end
        end else if (wd_expired) begin
          nxt       = ST_FAULT;
          set_fault = 1'b1;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up with its state.
  always_ff @(posedge clka) begin
    if (restart) begin
      st          <= ST_IDLE;
      wd_clr      <= 1'b1;
      start       <= 1'b0;
      load        <= 1'b0;
      decode      <= 1'b0;
      alu         <= 1'b0;
      display     <= 1'b0;
      guess_ready <= 1'b0;
      bad_guess   <= 1'b0;
      data        <= '0;
      turns       <= '0;
      won         <= 1'b0;
      lost        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      st          <= nxt;
      wd_clr      <= (nxt != st);
      start       <= (nxt == ST_PLACE);
      load        <= (nxt == ST_LOAD);
      decode      <= (nxt == ST_DECODE);
      alu         <= (nxt == ST_ALU);
      display     <= (nxt == ST_DISPLAY);
      guess_ready <= (nxt == ST_WAIT_GUESS);
      bad_guess   <= reject;
      if (accept) begin
        data <= guess;
        if (turns != TURN_MAX) begin
          turns <= turns + TURN_W'(1);
        end
      end
      if (clr_status) begin
        turns <= '0;
        won   <= 1'b0;
        lost  <= 1'b0;
        fault <= 1'b0;
      end else begin
        if (set_won)   won   <= 1'b1;
        if (set_lost)  lost  <= 1'b1;
        if (set_fault) fault <= 1'b1;
      end
    end
  end

endmodule
